// File: rtl/uart_byte_receiver.sv
// uart_byte_receiver: 8N1 LSB-first serial byte receiver with valid/framing_error strobes.
// Define RX_PARITY_EN for 8E1 frames with an even-parity check.
module uart_byte_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  output logic                 framing_error,
  output logic                 busy
);
  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;
  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [BW-1:0]          bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d, data_q, data_d;
  logic                   valid_q, valid_d, ferr_q, ferr_d;
  logic                   parity_ok;
`ifdef RX_PARITY_EN
  logic                   par_err_q, par_err_d;
  assign parity_ok = !par_err_q;
`else
  assign parity_ok = 1'b1;
`endif
  assign data          = data_q;
  assign valid         = valid_q;
  assign framing_error = ferr_q;
  assign busy          = state_q != IDLE;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end
`ifdef RX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) par_err_q <= 1'b0;
    else       par_err_q <= par_err_d;
  end
`endif
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef RX_PARITY_EN
    par_err_d = par_err_q;
`endif
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = START;
      end
      START: begin
        // a start bit that is high again at its midpoint was a glitch
        if (cnt_q == CNT_MID) begin
          state_d = rx_s_q ? IDLE : DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_d   = bit_q + BW'(1);
`ifdef RX_PARITY_EN
          if (bit_q == BIT_LAST) state_d = PARITY;
`else
          if (bit_q == BIT_LAST) state_d = STOP;
`endif
        end
      end
`ifdef RX_PARITY_EN
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          par_err_d = ^{shift_q, rx_s_q};
          state_d   = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          valid_d = rx_s_q && parity_ok;
          ferr_d  = !(rx_s_q && parity_ok);
          data_d  = (rx_s_q && parity_ok) ? shift_q : data_q;
          state_d = rx_s_q ? IDLE : WAIT_HIGH;
        end
      end
      WAIT_HIGH: begin
        // a held-low break line must not be re-read as a stream of frames
        cnt_d = '0;
        if (rx_s_q) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: doc/uart_byte_receiver.md
Name: uart_byte_receiver

Overview:
- Asynchronous serial (8N1, LSB first) byte receiver that recovers bytes from the raw `rx` pin.
- Sits directly upstream of the keyboard/cursor control block and the FIFO that feeds it.
- Presents the last good byte on `data` with a one-cycle `valid` strobe.
- Flags malformed frames on `framing_error` and never updates `data` for them.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per serial bit (100 MHz / 115200). Legal range ≥ 4.
- DATA_BITS, 8: payload bits per frame. Fixed at 8 for current use; implementation stays generic.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- rx  input  1  raw serial line, idle high, asynchronous to clk
- data  output  DATA_BITS  last correctly received byte, held until next good frame
- valid  output  1  single-cycle pulse when `data` updates
- framing_error  output  1  single-cycle pulse when a bad stop bit (or parity, if enabled) is sampled
- busy  output  1  high from start-bit detect until return to IDLE

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high. All flops clear on assertion of `reset` without waiting for `clk`.
- Reset values:
  - data=0, valid=0, framing_error=0, busy=0.
  - Synchroniser flops=1 (line idle). State=IDLE. Bit counter=0. Cycle counter=0.
- Input synchronisation:
  - `rx` passes through 2 flops before use. Call the result `rx_s`.
  - This adds a fixed 2-cycle latency.
- Cycle counter: width $clog2(CLKS_PER_BIT). Counts 0..CLKS_PER_BIT-1, then wraps to 0.
- States:
  - IDLE:
    - busy=0.
    - When rx_s=0: go to START, clear cycle counter, set busy=1.
  - START:
    - At cycle count CLKS_PER_BIT/2-1 (integer division), sample rx_s.
    - If 0: go to DATA, clear cycle counter and bit counter.
    - If 1 (glitch): go to IDLE and emit no pulse.
  - DATA:
    - At cycle count CLKS_PER_BIT-1, sample rx_s into the shift register, LSB first (shift right, new bit in MSB).
    - Increment the bit counter.
    - After bit DATA_BITS-1, go to STOP (or PARITY if enabled).
  - STOP:
    - At cycle count CLKS_PER_BIT-1, sample rx_s.
    - If 1: data <= shift register, valid=1 for exactly one cycle, go to IDLE.
    - If 0: framing_error=1 for one cycle, `data` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH:
    - Stay (busy=1) until rx_s=1, then go to IDLE.
    - This prevents a held-low break line from producing repeated frames.
- Latency: `valid` rises 2 + (CLKS_PER_BIT/2) + (DATA_BITS+1)·CLKS_PER_BIT cycles (±1) after the falling edge of the start bit on `rx`.
- Back-to-back frames:
  - Return to IDLE happens at mid-stop-bit.
  - A start bit immediately following the stop bit must be caught with no frame loss.
- `valid` and `framing_error` are mutually exclusive and never high in consecutive cycles for the same frame.
- Reset mid-frame:
  - Frame is discarded, no pulse.
  - After deassertion, the block re-arms in IDLE. If rx is still low at that point, it is treated as a new start bit.
- No backpressure. The consumer must take `data` on `valid`; the next good frame overwrites it.

Optional Feature:
- Macro: RX_PARITY_EN.
- Defined:
  - Frame is 8E1: a PARITY state follows DATA and samples one even-parity bit at CLKS_PER_BIT-1.
  - A parity mismatch is latched. In STOP, if the stop bit is good but parity was bad: framing_error pulses, `data` is not updated, next state is IDLE.
  - Total latency grows by CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; 8N1 only.

Test Plan (CLKS_PER_BIT=16 in sim, bits driven at exactly 16 cycles):
- Reset then idle line → data=0x00, valid=0, busy=0 held for 500 cycles; async reset clears outputs with no clk edge.
- Send 0x77 ('w') → exactly one valid pulse 2+8+144 (±1) cycles after the start edge, data=0x77, framing_error never 1.
- Send 0x61, 0x73, 0x64 back-to-back with zero idle → three valid pulses, data sequence 0x61, 0x73, 0x64, no errors.
- rx low pulse of 5 cycles, then high → returns to IDLE, busy drops, no valid or framing_error.
- Send 0x55 with stop bit=0, then hold rx low 100 cycles, then 0x41 → one framing_error, data stays previous value, no second pulse during the low hold, then valid with data=0x41.
- Assert reset midway through the data bits of 0x3C, release, send 0xA5 → no pulse for 0x3C, valid with data=0xA5. With RX_PARITY_EN, 0xA5 with odd parity bit → framing_error, data unchanged.
